isp_frame_sequencer: RTL and testbench
======================================

ISP_FRAME_SEQUENCER -- requirements
Module: isp_frame_sequencer

Interface
REQ-001 Parameter WIDTH, default 320: active pixels per row.
REQ-002 Parameter HEIGHT, default 240: active rows per frame.
REQ-003 Parameter HBLANK, default 16: invalid cycles inserted after every row.
REQ-004 Parameter SOF_GAP, default 32: cycles from the newFrame pulse to the first pixel slot.
REQ-005 Parameter MAX_FLUSH, default 4: flush-row limit before timeout.
REQ-006 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-007 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port i_start, input, 1: one-cycle request to process one frame; ignored unless IDLE.
REQ-009 Port i_valid, input, 1: source pixel valid.
REQ-010 Port i_data, input, 8: source raw Bayer pixel.
REQ-011 Port o_ready, output, 1: sequencer accepts a pixel this cycle.
REQ-012 Port o_newFrame, output, 1: one-cycle start-of-frame pulse to the processing pipeline.
REQ-013 Port o_valid, output, 1: pipeline iValid.
REQ-014 Port o_data, output, 8: pipeline iData.
REQ-015 Port i_pipe_done, input, 1: pipeline end-of-frame indication (oDoneDemosaic).
REQ-016 Port o_busy, output, 1: high in every state except IDLE.
REQ-017 Port o_frame_done, output, 1: one-cycle pulse at normal frame completion.
REQ-018 Port o_timeout, output, 1: sticky flag; set when the flush limit is exceeded; cleared by i_start.

Function
REQ-019 The FSM SHALL have states IDLE, SOF, ACTIVE, HBLANK, FLUSH, FBLANK and DONE.
REQ-020 IDLE->SOF on i_start: o_newFrame=1 for exactly the first SOF cycle; SOF lasts SOF_GAP cycles, then ->ACTIVE.
REQ-021 ACTIVE: o_ready=1. Each i_valid&o_ready handshake is registered: o_valid=1 and o_data=i_data on the next cycle (latency 1). Cycles with no handshake give o_valid=0, and the column count holds.
REQ-022 o_ready SHALL be 0 in every state other than ACTIVE, and SHALL drop combinationally in the cycle after the WIDTH-th accepted pixel of a row.
REQ-023 After the WIDTH-th pixel: ->HBLANK for exactly HBLANK cycles with o_valid=0, then ->ACTIVE, or ->FLUSH if the row just completed was HEIGHT-1.
REQ-024 FLUSH: o_valid=1 and o_data=0 for exactly WIDTH consecutive cycles, then ->FBLANK (HBLANK cycles, o_valid=0).
REQ-025 i_pipe_done SHALL be latched into a sticky bit in any non-IDLE state. At the end of FLUSH, if the bit is set ->DONE; otherwise FBLANK then another FLUSH row.
REQ-026 If MAX_FLUSH flush rows complete without done: set o_timeout and ->DONE without an o_frame_done pulse.
REQ-027 DONE lasts 1 cycle; it pulses o_frame_done when there is no timeout, then ->IDLE.
REQ-028 Counters: column 0..WIDTH-1, row 0..HEIGHT-1, blank 0..max(HBLANK,SOF_GAP)-1. Each counter uses the minimum clog2 width and wraps to 0 at its terminal count.
REQ-029 i_start in a non-IDLE state SHALL be ignored; a frame in progress is never restarted.
REQ-030 i_pipe_done asserted at the same time as the last FLUSH cycle SHALL count as done for that row.

Reset
REQ-031 Asserting reset_n low SHALL immediately force IDLE, zero all counters, set o_ready/o_newFrame/o_valid/o_busy/o_frame_done/o_timeout to 0 and o_data to 0, and clear the sticky done bit, including in the middle of a frame.
REQ-032 After reset_n is released, the block SHALL stay in IDLE until i_start.

Structure
REQ-033 The state enum and default timing constants SHALL live in package isp_pkg.
REQ-034 The design SHALL be one module with no submodules; the column/row/blank counters are inline.

Verification
REQ-035 WIDTH=8, HEIGHT=4, HBLANK=2, SOF_GAP=3, source always valid, i_start pulse -> o_newFrame high for 1 cycle, first o_valid 4 cycles after the pulse cycle, 8 valid/2 blank per row, 32 pixels passed bit-exact.
REQ-036 Source drops i_valid randomly -> o_valid count per row still 8, o_data sequence matches input order, HBLANK still 2.
REQ-037 i_pipe_done asserted during the 1st flush row -> exactly 8 zero-data valid cycles, then o_frame_done pulse, then IDLE.
REQ-038 i_pipe_done never asserted, MAX_FLUSH=4 -> 4 flush rows, o_timeout=1, no o_frame_done; next i_start clears o_timeout.
REQ-039 reset_n low in the middle of row 2 -> all outputs 0 asynchronously; a following i_start runs a clean full frame.
REQ-040 i_start pulsed during ACTIVE -> no extra o_newFrame, and frame timing is unchanged.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared state encoding, default frame timing and counter sizing helper for the ISP frame sequencer.
package isp_pkg;

  localparam int DEF_WIDTH     = 320;
  localparam int DEF_HEIGHT    = 240;
  localparam int DEF_HBLANK    = 16;
  localparam int DEF_SOF_GAP   = 32;
  localparam int DEF_MAX_FLUSH = 4;
  localparam int DATA_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ACTIVE,
    ST_HBLANK,
    ST_FLUSH,
    ST_FBLANK,
    ST_DONE
  } seq_state_e;

  // Minimum counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/isp_frame_sequencer.sv
// Feeds one raw Bayer frame into the ISP pipeline: start-of-frame gap, WIDTH x HEIGHT pixels
// with row blanking, then zero-data flush rows until the pipeline reports end of frame.
module isp_frame_sequencer
  import isp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int HBLANK    = DEF_HBLANK,
  parameter int SOF_GAP   = DEF_SOF_GAP,
  parameter int MAX_FLUSH = DEF_MAX_FLUSH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_newFrame,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_pipe_done,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_timeout
);

  localparam int BLANK_MAX = (HBLANK > SOF_GAP) ? HBLANK : SOF_GAP;
  localparam int CW = cntWidth(WIDTH);
  localparam int RW = cntWidth(HEIGHT);
  localparam int BW = cntWidth(BLANK_MAX);
  localparam int FW = cntWidth(MAX_FLUSH);

  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [BW-1:0] SOF_LAST   = BW'(SOF_GAP - 1);
  localparam logic [BW-1:0] HB_LAST    = BW'(HBLANK - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(MAX_FLUSH - 1);

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              doneSeen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      blank_q   <= '0;
      flush_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      blank_q   <= blank_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  // A done arriving in the very last flush cycle still counts for that row.
  assign doneSeen = done_q | i_pipe_done;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    blank_d   = blank_q;
    flush_d   = flush_q;
    done_d    = (state_q == ST_IDLE) ? 1'b0 : doneSeen;
    timeout_d = timeout_q;
    valid_d   = 1'b0;
    data_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          timeout_d = 1'b0;
          col_d     = '0;
          row_d     = '0;
          blank_d   = '0;
          flush_d   = '0;
          state_d   = ST_SOF;
        end
      end
      ST_SOF: begin
        if (blank_q == SOF_LAST) begin
          blank_d = '0;
          state_d = ST_ACTIVE;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (i_valid) begin
          valid_d = 1'b1;
          data_d  = i_data;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_HBLANK;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_HBLANK: begin
        if (blank_q == HB_LAST) begin
          blank_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = ST_FLUSH;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_ACTIVE;
          end
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        valid_d = 1'b1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (doneSeen) begin
            state_d = ST_DONE;
          end else if (flush_q == FLUSH_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            flush_d = flush_q + 1'b1;
            state_d = ST_FBLANK;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_FBLANK: begin
        if (blank_q == HB_LAST) begin
          blank_d = '0;
          state_d = ST_FLUSH;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_ready      = (state_q == ST_ACTIVE);
  assign o_newFrame   = (state_q == ST_SOF) && (blank_q == '0);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = (state_q == ST_DONE) && !timeout_q;
  assign o_timeout    = timeout_q;
  assign o_valid      = valid_q;
  assign o_data       = data_q;

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// Bench for isp_frame_sequencer: builds the expected per-cycle output timeline of each
// frame from the stimulus tables, then compares the DUT against it every cycle.
module tb_isp_frame_sequencer;
  import isp_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int SG = 3;
  localparam int MF = 4;
  localparam int NC = 400;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_start, i_valid, i_pipe_done;
  logic [7:0] i_data;
  logic       o_ready, o_newFrame, o_valid, o_busy, o_frame_done, o_timeout;
  logic [7:0] o_data;

  int    checks   = 0;
  int    failures = 0;
  int    validSeen;
  string scen;

  bit         stStart [NC];
  bit         stValid [NC];
  bit         stDone  [NC];
  logic [7:0] stData  [NC];

  bit         eReady [NC];
  bit         eNew   [NC];
  bit         eValid [NC];
  bit         eBusy  [NC];
  bit         eFDone [NC];
  bit         eTmo   [NC];
  logic [7:0] eData  [NC];

  isp_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .SOF_GAP(SG), .MAX_FLUSH(MF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_newFrame(o_newFrame), .o_valid(o_valid), .o_data(o_data),
    .i_pipe_done(i_pipe_done), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic compare(input string what, input int n, input logic [7:0] got,
                         input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s %s cyc=%0d got=%0h exp=%0h", scen, what, n, got, exp);
    end
  endtask

  task automatic pin(input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s pin %s got=%0d exp=%0d", scen, what, got, exp);
    end
  endtask

  task automatic clearStim(input bit allValid);
    for (int n = 0; n < NC; n++) begin
      stStart[n] = 1'b0;
      stDone[n]  = 1'b0;
      stValid[n] = allValid ? 1'b1 : ($urandom_range(0, 2) != 0);
      stData[n]  = allValid ? 8'((n * 37 + 5) & 255) : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic mark(input int k, input logic [7:0] d);
    if (k < NC) begin
      eValid[k] = 1'b1;
      eData[k]  = d;
    end
  endtask

  // One frame accepted at cycle s: pixels follow the source pattern, blanking is pure
  // cycle arithmetic, flush rows end on any done seen since the frame started.
  task automatic modelFrame(input int s, output int doneCyc, output bit timedOut);
    int t;
    int acc;
    bit seen;
    t        = s + 1;
    doneCyc  = -1;
    timedOut = 1'b0;
    if (t < NC) eNew[t] = 1'b1;
    t += SG;
    for (int r = 0; r < H; r++) begin
      acc = 0;
      while (acc < W && t < NC) begin
        eReady[t] = 1'b1;
        if (stValid[t]) begin
          mark(t + 1, stData[t]);
          acc++;
        end
        t++;
      end
      t += HB;
    end
    for (int f = 0; f < MF && doneCyc < 0; f++) begin
      for (int c = 0; c < W; c++) begin
        mark(t + 1, 8'h00);
        t++;
      end
      seen = 1'b0;
      for (int k = s + 1; k < t && k < NC; k++) if (stDone[k]) seen = 1'b1;
      if (seen) doneCyc = t;
      else if (f == MF - 1) begin
        doneCyc  = t;
        timedOut = 1'b1;
      end else t += HB;
    end
    for (int k = s + 1; k <= doneCyc && k < NC; k++) eBusy[k] = 1'b1;
    if (!timedOut && doneCyc < NC) eFDone[doneCyc] = 1'b1;
  endtask

  task automatic buildExpected();
    int prevDone;
    int tmoFrom;
    int d;
    bit tmo;
    for (int n = 0; n < NC; n++) begin
      eReady[n] = 0; eNew[n] = 0; eValid[n] = 0; eBusy[n] = 0;
      eFDone[n] = 0; eTmo[n] = 0; eData[n] = 8'h00;
    end
    prevDone = -1;
    tmoFrom  = -1;
    for (int n = 0; n < NC; n++) begin
      if (stStart[n] && n > prevDone) begin
        if (tmoFrom >= 0) for (int k = tmoFrom; k <= n; k++) eTmo[k] = 1'b1;
        tmoFrom = -1;
        modelFrame(n, d, tmo);
        prevDone = d;
        if (tmo) tmoFrom = d;
      end
    end
    if (tmoFrom >= 0) for (int k = tmoFrom; k < NC; k++) eTmo[k] = 1'b1;
  endtask

  task automatic applyStimulus(input int n);
    i_start     = stStart[n];
    i_valid     = stValid[n];
    i_data      = stData[n];
    i_pipe_done = stDone[n];
  endtask

  task automatic checkZero(input string tag);
    compare({tag, " o_ready"}, -1, {7'b0, o_ready}, 8'h00);
    compare({tag, " o_newFrame"}, -1, {7'b0, o_newFrame}, 8'h00);
    compare({tag, " o_valid"}, -1, {7'b0, o_valid}, 8'h00);
    compare({tag, " o_data"}, -1, o_data, 8'h00);
    compare({tag, " o_busy"}, -1, {7'b0, o_busy}, 8'h00);
    compare({tag, " o_frame_done"}, -1, {7'b0, o_frame_done}, 8'h00);
    compare({tag, " o_timeout"}, -1, {7'b0, o_timeout}, 8'h00);
  endtask

  task automatic checkOutput(input int n);
    compare("o_ready", n, {7'b0, o_ready}, {7'b0, eReady[n]});
    compare("o_newFrame", n, {7'b0, o_newFrame}, {7'b0, eNew[n]});
    compare("o_valid", n, {7'b0, o_valid}, {7'b0, eValid[n]});
    if (eValid[n]) compare("o_data", n, o_data, eData[n]);
    compare("o_busy", n, {7'b0, o_busy}, {7'b0, eBusy[n]});
    compare("o_frame_done", n, {7'b0, o_frame_done}, {7'b0, eFDone[n]});
    compare("o_timeout", n, {7'b0, o_timeout}, {7'b0, eTmo[n]});
  endtask

  task automatic applyReset();
    reset_n     = 1'b0;
    i_start     = 1'b0;
    i_valid     = 1'b0;
    i_data      = 8'h00;
    i_pipe_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkZero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic runScenario(input string name, input int ncyc, input int abortAt);
    scen = name;
    buildExpected();
    validSeen = 0;
    applyReset();
    for (int n = 0; n < ncyc; n++) begin
      applyStimulus(n);
      @(negedge clk);
      checkOutput(n);
      if (o_valid === 1'b1) validSeen++;
      if (n == abortAt) begin
        #1 reset_n = 1'b0;
        #1 checkZero("async_reset");
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_start = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_pipe_done = 1'b0;

    // Always-valid source, extra start during ACTIVE, done inside the first flush row.
    clearStim(1'b1);
    stStart[2] = 1'b1; stStart[20] = 1'b1; stDone[48] = 1'b1;
    runScenario("basic", 70, -1);
    pin("newFrame@3", int'(eNew[3]), 1);
    pin("newFrame@4", int'(eNew[4]), 0);
    pin("valid@6", int'(eValid[6]), 0);
    pin("valid@7", int'(eValid[7]), 1);
    pin("rowgap@15", int'(eValid[15]), 0);
    pin("frameDone@54", int'(eFDone[54]), 1);
    pin("busy@55", int'(eBusy[55]), 0);
    pin("validCount", validSeen, 40);

    // Bursty source; done arrives early and must stay latched until the flush row ends.
    clearStim(1'b0);
    stStart[2] = 1'b1; stDone[10] = 1'b1;
    runScenario("bursty", 150, -1);
    pin("validCount", validSeen, 40);

    // No done: four flush rows then timeout; the next start clears it and runs normally.
    clearStim(1'b1);
    stStart[2] = 1'b1; stStart[100] = 1'b1; stDone[120] = 1'b1;
    runScenario("timeout", 170, -1);
    pin("tmo@83", int'(eTmo[83]), 0);
    pin("tmo@84", int'(eTmo[84]), 1);
    pin("frameDone@84", int'(eFDone[84]), 0);
    pin("tmo@100", int'(eTmo[100]), 1);
    pin("tmo@101", int'(eTmo[101]), 0);
    pin("validCount", validSeen, 104);

    // Done exactly on the last flush cycle counts; one cycle later costs another row.
    clearStim(1'b1);
    stStart[2] = 1'b1; stDone[53] = 1'b1; stStart[60] = 1'b1; stDone[112] = 1'b1;
    runScenario("doneEdge", 140, -1);
    pin("frameDone@54", int'(eFDone[54]), 1);
    pin("frameDone@112", int'(eFDone[112]), 0);
    pin("frameDone@122", int'(eFDone[122]), 1);
    pin("validCount", validSeen, 88);

    clearStim(1'b1);
    stStart[2] = 1'b1; stDone[10] = 1'b1;
    runScenario("abortRow2", 60, 28);
    pin("validCount", validSeen, 18);

    clearStim(1'b1);
    stStart[2] = 1'b1; stDone[48] = 1'b1;
    runScenario("afterAbort", 70, -1);
    pin("validCount", validSeen, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
